ifmap_spad_ctrl: RTL

IFMAP_SPAD_CTRL -- requirements
Module: ifmap_spad_ctrl

---
 rtl/ifmap_spad_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ifmap_spad_ctrl.sv
// Ifmap scratch-pad controller: loads one ifmap row into a negedge scratch pad,
// then replays every sliding filter window (offset fastest) to the MAC.
module ifmap_spad_ctrl #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] row_len,
  input  logic [ADDR_W-1:0] filt_len,
  output logic              busy,
  output logic              err,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_wdata,
  input  logic [DATA_W-1:0] spad_rdata,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready are both 1;
  // valid never drops and its payload never changes until that transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, READ = 2'd2} state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d, filt_q, filt_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d, b_q, b_d, o_q, o_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d, busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic                ov_q, ov_d, last_q, last_d;
  logic                legal;

  assign legal = (row_len != '0) && (row_len <= DEPTH_A) &&
                 (filt_len != '0) && (filt_len <= row_len);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    filt_d  = filt_q;
    wptr_d  = wptr_q;
    b_d     = b_q;
    o_d     = o_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    ov_d    = ov_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        ov_d = 1'b0;
        if (start) begin
          if (legal) begin
            row_d   = row_len;
            filt_d  = filt_len;
            wptr_d  = '0;
            busy_d  = 1'b1;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          we_d    = 1'b1;
          addr_d  = wptr_q;
          wdata_d = in_data;
          if (wptr_q == row_q - ONE) begin
            wptr_d  = '0;
            state_d = READ;
          end else begin
            wptr_d = wptr_q + ONE;
          end
        end
      end
      READ: begin
        // out_valid low here means this is the first READ cycle: prime address 0.
        if (!ov_q) begin
          b_d    = '0;
          o_d    = '0;
          addr_d = '0;
          ov_d   = 1'b1;
          last_d = (filt_q == ONE);
        end else if (out_ready) begin
          if (o_q == filt_q - ONE) begin
            if (b_q == row_q - filt_q) begin
              ov_d    = 1'b0;
              last_d  = 1'b0;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              b_d    = b_q + ONE;
              o_d    = '0;
              addr_d = b_q + ONE;
              last_d = (filt_q == ONE);
            end
          end else begin
            o_d    = o_q + ONE;
            addr_d = b_q + o_q + ONE;
            last_d = (o_q + ONE == filt_q - ONE);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      filt_q  <= '0;
      wptr_q  <= '0;
      b_q     <= '0;
      o_q     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      filt_q  <= filt_d;
      wptr_q  <= wptr_d;
      b_q     <= b_d;
      o_q     <= o_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign out_data   = spad_rdata;
  assign out_valid  = ov_q;
  assign out_last   = last_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign done       = done_q;
  assign spad_addr  = addr_q;
  assign spad_we    = we_q;
  assign spad_wdata = wdata_q;
  assign dbg_state  = state_q;

endmodule
